// File: rtl/msrh_csu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : msrh_csu_pkg
//  Description : Shared definitions for the CSU CSR file: CSR addresses,
//                write-queue entry type, write legalization and decode.
//  Revision    : 1.0 - initial release
// ============================================================================
package msrh_csu_pkg;

  localparam int XLEN = 64;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;

  typedef struct packed {
    logic [11:0]     addr;
    logic [XLEN-1:0] data;
  } csr_wq_entry_t;

  // True when the address names a CSR held in this file
  function automatic logic csr_is_impl(input logic [11:0] addr);
    case (addr)
      CSR_MSTATUS, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
      CSR_MCAUSE, CSR_MTVAL, CSR_MCYCLE: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

  // Apply WARL rules at enqueue so forwarded data already matches what lands
  function automatic logic [XLEN-1:0] csr_wr_legalize(input logic [11:0]     addr,
                                                      input logic [XLEN-1:0] data);
    logic [XLEN-1:0] r_val;
    r_val = data;
    if (addr == CSR_MEPC) begin
      r_val[0] = 1'b0;
    end else if (addr == CSR_MTVEC && data[1]) begin
      // modes 2 and 3 are reserved; fall back to direct mode
      r_val[1:0] = 2'b00;
    end
    return r_val;
  endfunction

endpackage
`default_nettype wire

// File: rtl/msrh_csr_wq.sv
`default_nettype none
// ============================================================================
//  Module      : msrh_csr_wq
//  Description : Circular CSR write queue, WR_PORT_NUM enqueue ports, one
//                dequeue per cycle, flush, full entry array for forwarding.
//  Revision    : 1.0 - initial release
// ============================================================================
module msrh_csr_wq
  import msrh_csu_pkg::*;
#(
  parameter int WR_PORT_NUM = 2,
  parameter int WQ_DEPTH    = 4
) (
  input  logic                                       i_clk,
  input  logic                                       i_reset_n,
  input  logic                                       i_flush,
  input  logic                                       i_enq_en,
  input  logic [WR_PORT_NUM-1:0]                     i_enq_valid,
  input  csr_wq_entry_t [WR_PORT_NUM-1:0]            i_enq_entry,
  output logic                                       o_deq_valid,
  output csr_wq_entry_t                              o_deq_entry,
  output csr_wq_entry_t [WQ_DEPTH-1:0]               o_entries,
  output logic [$clog2(WQ_DEPTH)-1:0]                o_head,
  output logic [$clog2(WQ_DEPTH):0]                  o_count
);

  localparam int PTR_W = $clog2(WQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  csr_wq_entry_t [WQ_DEPTH-1:0]      r_entry;
  logic [PTR_W-1:0]                  r_head;
  logic [PTR_W-1:0]                  r_tail;
  logic [CNT_W-1:0]                  r_count;
  logic [WR_PORT_NUM-1:0][PTR_W-1:0] w_slot;
  logic [CNT_W-1:0]                  w_n_enq;
  logic                              w_go;
  logic                              w_deq;

  assign w_go  = i_enq_en & ~i_flush;
  assign w_deq = (r_count != '0) & ~i_flush;

  // Pack valid channels into consecutive slots, lower channel index first
  always_comb begin
    w_n_enq = '0;
    for (int ch = 0; ch < WR_PORT_NUM; ch++) begin
      w_slot[ch] = r_tail + w_n_enq[PTR_W-1:0];
      if (w_go && i_enq_valid[ch]) begin
        w_n_enq = w_n_enq + CNT_W'(1);
      end
    end
  end

  // Queue storage, pointers and occupancy; flush discards everything incl. this cycle's drain
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_entry <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      for (int ch = 0; ch < WR_PORT_NUM; ch++) begin
        if (w_go && i_enq_valid[ch]) begin
          r_entry[w_slot[ch]] <= i_enq_entry[ch];
        end
      end
      r_tail  <= r_tail + w_n_enq[PTR_W-1:0];
      if (w_deq) begin
        r_head <= r_head + PTR_W'(1);
      end
      r_count <= r_count + w_n_enq - CNT_W'(w_deq);
    end
  end

  assign o_deq_valid = w_deq;
  assign o_deq_entry = r_entry[r_head];
  assign o_entries   = r_entry;
  assign o_head      = r_head;
  assign o_count     = r_count;

endmodule
`default_nettype wire

// File: rtl/msrh_csr_mport_file.sv
`default_nettype none
// ============================================================================
//  Module      : msrh_csr_mport_file
//  Description : Multi-port machine-mode CSR file. Writes are queued and
//                retire one per cycle; reads forward from the queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module msrh_csr_mport_file
  import msrh_csu_pkg::*;
#(
  parameter int RD_PORT_NUM = 2,
  parameter int WR_PORT_NUM = 2,
  parameter int WQ_DEPTH    = 4
) (
  input  logic                                   i_clk,
  input  logic                                   i_reset_n,
  input  logic [RD_PORT_NUM-1:0]                 i_rd_valid,
  input  logic [RD_PORT_NUM-1:0][11:0]           i_rd_addr,
  output logic [RD_PORT_NUM-1:0][XLEN-1:0]       o_rd_data,
  output logic [RD_PORT_NUM-1:0]                 o_rd_illegal,
  input  logic [WR_PORT_NUM-1:0]                 i_wr_valid,
  input  logic [WR_PORT_NUM-1:0][11:0]           i_wr_addr,
  input  logic [WR_PORT_NUM-1:0][XLEN-1:0]       i_wr_data,
  output logic                                   o_wr_ready,
  input  logic                                   i_trap_valid,
  input  logic [XLEN-1:0]                        i_trap_epc,
  input  logic [XLEN-1:0]                        i_trap_cause,
  input  logic [XLEN-1:0]                        i_trap_tval,
  output logic [XLEN-1:0]                        o_mepc,
  output logic [XLEN-1:0]                        o_mtvec,
  output logic [$clog2(WQ_DEPTH):0]              o_wq_count,
  output logic                                   o_wq_empty
);

  localparam int PTR_W = $clog2(WQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [XLEN-1:0] r_mstatus, r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval, r_mcycle;

  csr_wq_entry_t [WR_PORT_NUM-1:0] w_enq_entry;
  csr_wq_entry_t [WQ_DEPTH-1:0]    w_entries;
  csr_wq_entry_t                   w_deq_entry;
  logic                            w_deq_valid;
  logic [PTR_W-1:0]                w_head;
  logic [CNT_W-1:0]                w_count;
  logic                            w_enq_en;

  for (genvar g = 0; g < WR_PORT_NUM; g++) begin : g_wr_legal
    assign w_enq_entry[g] = '{addr: i_wr_addr[g],
                              data: csr_wr_legalize(i_wr_addr[g], i_wr_data[g])};
  end

  assign o_wr_ready = (w_count <= CNT_W'(WQ_DEPTH - WR_PORT_NUM));
  // a trap kills the whole cycle's write traffic
  assign w_enq_en   = o_wr_ready & ~i_trap_valid;

  msrh_csr_wq #(
    .WR_PORT_NUM (WR_PORT_NUM),
    .WQ_DEPTH    (WQ_DEPTH)
  ) u_wq (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_flush     (i_trap_valid),
    .i_enq_en    (w_enq_en),
    .i_enq_valid (i_wr_valid),
    .i_enq_entry (w_enq_entry),
    .o_deq_valid (w_deq_valid),
    .o_deq_entry (w_deq_entry),
    .o_entries   (w_entries),
    .o_head      (w_head),
    .o_count     (w_count)
  );

  for (genvar g = 0; g < RD_PORT_NUM; g++) begin : g_rd
    logic            w_hit;
    logic [XLEN-1:0] w_fwd;
    logic [XLEN-1:0] w_arch;
    logic [PTR_W-1:0] w_idx;

    // Walk oldest to youngest so the youngest matching entry wins; then arch fallback
    always_comb begin
      w_hit = 1'b0;
      w_fwd = '0;
      w_idx = '0;
      for (int i = 0; i < WQ_DEPTH; i++) begin
        w_idx = w_head + PTR_W'(i);
        if ((CNT_W'(i) < w_count) && (w_entries[w_idx].addr == i_rd_addr[g])) begin
          w_hit = 1'b1;
          w_fwd = w_entries[w_idx].data;
        end
      end
      case (i_rd_addr[g])
        CSR_MSTATUS:  w_arch = r_mstatus;
        CSR_MTVEC:    w_arch = r_mtvec;
        CSR_MSCRATCH: w_arch = r_mscratch;
        CSR_MEPC:     w_arch = r_mepc;
        CSR_MCAUSE:   w_arch = r_mcause;
        CSR_MTVAL:    w_arch = r_mtval;
        CSR_MCYCLE:   w_arch = r_mcycle;
        default:      w_arch = '0;
      endcase
      // unimplemented addresses read zero even if a write to them is still queued
      if (!csr_is_impl(i_rd_addr[g])) begin
        o_rd_data[g] = '0;
      end else if (w_hit) begin
        o_rd_data[g] = w_fwd;
      end else begin
        o_rd_data[g] = w_arch;
      end
      o_rd_illegal[g] = i_rd_valid[g] & ~csr_is_impl(i_rd_addr[g]);
    end
  end

  // Architectural CSRs: trap update beats the drain; a drain into mcycle beats the increment
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_mstatus  <= '0;
      r_mtvec    <= '0;
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
      r_mtval    <= '0;
      r_mcycle   <= '0;
    end else begin
      r_mcycle <= r_mcycle + XLEN'(1);
      if (i_trap_valid) begin
        r_mepc   <= {i_trap_epc[XLEN-1:1], 1'b0};
        r_mcause <= i_trap_cause;
        r_mtval  <= i_trap_tval;
      end else if (w_deq_valid) begin
        case (w_deq_entry.addr)
          CSR_MSTATUS:  r_mstatus  <= w_deq_entry.data;
          CSR_MTVEC:    r_mtvec    <= w_deq_entry.data;
          CSR_MSCRATCH: r_mscratch <= w_deq_entry.data;
          CSR_MEPC:     r_mepc     <= w_deq_entry.data;
          CSR_MCAUSE:   r_mcause   <= w_deq_entry.data;
          CSR_MTVAL:    r_mtval    <= w_deq_entry.data;
          CSR_MCYCLE:   r_mcycle   <= w_deq_entry.data;
          default:      ;
        endcase
      end
    end
  end

  assign o_mepc     = r_mepc;
  assign o_mtvec    = r_mtvec;
  assign o_wq_count = w_count;
  assign o_wq_empty = (w_count == '0);

endmodule
`default_nettype wire

// File: tb/tb_msrh_csr_mport_file.sv
`default_nettype none
// ============================================================================
//  Module      : tb_msrh_csr_mport_file
//  Description : Self-checking bench for msrh_csr_mport_file: directed
//                sequences, a legalization table and random traffic checked
//                against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_msrh_csr_mport_file;
  import msrh_csu_pkg::*;

  localparam int RD = 2;
  localparam int WR = 2;
  localparam int D  = 4;
  localparam int W  = XLEN;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [RD-1:0]        rd_valid;
  logic [RD-1:0][11:0]  rd_addr;
  logic [RD-1:0][W-1:0] rd_data;
  logic [RD-1:0]        rd_ill;
  logic [WR-1:0]        wr_valid;
  logic [WR-1:0][11:0]  wr_addr;
  logic [WR-1:0][W-1:0] wr_data;
  logic                 wr_ready;
  logic                 trap_valid;
  logic [W-1:0]         trap_epc, trap_cause, trap_tval;
  logic [W-1:0]         mepc, mtvec;
  logic [2:0]           wq_count;
  logic                 wq_empty;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  msrh_csr_mport_file #(.RD_PORT_NUM(RD), .WR_PORT_NUM(WR), .WQ_DEPTH(D)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_rd_valid(rd_valid), .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_rd_illegal(rd_ill),
    .i_wr_valid(wr_valid), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_ready(wr_ready),
    .i_trap_valid(trap_valid), .i_trap_epc(trap_epc), .i_trap_cause(trap_cause),
    .i_trap_tval(trap_tval), .o_mepc(mepc), .o_mtvec(mtvec),
    .o_wq_count(wq_count), .o_wq_empty(wq_empty)
  );

  // ---------------- reference model ----------------
  typedef struct { logic [11:0] a; logic [W-1:0] d; } wq_t;
  wq_t          mq[$];
  logic [W-1:0] march[int];
  logic [11:0]  pool[8] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'hB00, 12'h7C0};

  function automatic bit m_impl(logic [11:0] a);
    return a inside {12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'hB00};
  endfunction

  function automatic logic [W-1:0] m_legal(logic [11:0] a, logic [W-1:0] d);
    if (a == 12'h341) return d & ~W'(1);
    if (a == 12'h305 && d[1:0] >= 2'd2) return {d[W-1:2], 2'b00};
    return d;
  endfunction

  function automatic logic [W-1:0] m_read(logic [11:0] a);
    if (!m_impl(a)) return '0;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].a == a) return mq[i].d;
    return march[int'(a)];
  endfunction

  task automatic m_reset();
    mq.delete();
    for (int i = 0; i < 7; i++) march[int'(pool[i])] = '0;
  endtask

  task automatic m_step();
    bit  rdy;
    wq_t e;
    rdy = (mq.size() <= D - WR);
    march[int'(12'hB00)] = march[int'(12'hB00)] + W'(1);
    if (trap_valid) begin
      mq.delete();
      march[int'(12'h341)] = trap_epc & ~W'(1);
      march[int'(12'h342)] = trap_cause;
      march[int'(12'h343)] = trap_tval;
    end else begin
      if (mq.size() > 0) begin
        e = mq.pop_front();
        if (m_impl(e.a)) march[int'(e.a)] = e.d;
      end
      if (rdy)
        for (int ch = 0; ch < WR; ch++)
          if (wr_valid[ch]) begin
            e.a = wr_addr[ch];
            e.d = m_legal(wr_addr[ch], wr_data[ch]);
            mq.push_back(e);
          end
    end
  endtask

  // ---------------- helpers ----------------
  task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    rd_valid = '0; rd_addr = '0;
    wr_valid = '0; wr_addr = '0; wr_data = '0;
    trap_valid = 1'b0; trap_epc = '0; trap_cause = '0; trap_tval = '0;
  endtask

  // Compare every output to the model, then advance one clock
  task automatic tick();
    bit ill;
    #1;
    for (int ch = 0; ch < RD; ch++) begin
      ill = rd_valid[ch] && !m_impl(rd_addr[ch]);
      if (rd_valid[ch]) chk($sformatf("rd_data[%0d]", ch), rd_data[ch], m_read(rd_addr[ch]));
      chk($sformatf("rd_illegal[%0d]", ch), W'(rd_ill[ch]), W'(ill));
    end
    chk("wr_ready", W'(wr_ready), W'(mq.size() <= D - WR));
    chk("wq_count", W'(wq_count), W'(mq.size()));
    chk("wq_empty", W'(wq_empty), W'(mq.size() == 0));
    chk("mepc", mepc, march[int'(12'h341)]);
    chk("mtvec", mtvec, march[int'(12'h305)]);
    @(posedge clk);
    m_step();
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic wr(int ch, logic [11:0] a, logic [W-1:0] d);
    wr_valid[ch] = 1'b1; wr_addr[ch] = a; wr_data[ch] = d;
  endtask

  task automatic rd(int ch, logic [11:0] a);
    rd_valid[ch] = 1'b1; rd_addr[ch] = a;
  endtask

  typedef struct {
    logic [11:0]  a;
    logic [W-1:0] wd;
    logic [W-1:0] exp_d;
    logic         exp_ill;
  } vec_t;
  vec_t tbl[10];

  initial begin
    tbl[0] = '{12'h300, 64'hDEAD_BEEF_0000_1234, 64'hDEAD_BEEF_0000_1234, 1'b0};
    tbl[1] = '{12'h305, 64'h103,                 64'h100,                 1'b0};
    tbl[2] = '{12'h305, 64'h101,                 64'h101,                 1'b0};
    tbl[3] = '{12'h305, 64'h102,                 64'h100,                 1'b0};
    tbl[4] = '{12'h341, 64'h8000_0003,           64'h8000_0002,           1'b0};
    tbl[5] = '{12'h340, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    tbl[6] = '{12'h342, 64'h8000_0000_0000_000B, 64'h8000_0000_0000_000B, 1'b0};
    tbl[7] = '{12'h343, 64'h1234,                64'h1234,                1'b0};
    tbl[8] = '{12'h7C0, 64'h55,                  64'h0,                   1'b1};
    tbl[9] = '{12'h301, 64'h99,                  64'h0,                   1'b1};

    clear_inputs();
    rst_n = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_empty", W'(wq_empty), W'(1));
    chk("reset_ready", W'(wr_ready), W'(1));
    chk("reset_count", W'(wq_count), W'(0));
    chk("reset_mepc", mepc, '0);
    chk("reset_mtvec", mtvec, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // mcycle counts from reset release
    repeat (3) tick();
    rd(0, 12'hB00);
    #1 chk("mcycle_3", rd_data[0], W'(3));
    tick();

    // mepc write: invisible same cycle, forwarded next, architectural after drain
    wr(0, 12'h341, 64'h8000_0003); rd(0, 12'h341);
    #1 chk("mepc_same_cycle", rd_data[0], '0);
    tick();
    rd(0, 12'h341);
    #1 chk("mepc_forward", rd_data[0], 64'h8000_0002);
    chk("mepc_arch_before", mepc, '0);
    tick();
    #1 chk("mepc_after_drain", mepc, 64'h8000_0002);
    tick();

    // same-cycle writes to one CSR: higher channel is younger
    wr(0, 12'h340, 64'h11); wr(1, 12'h340, 64'h22);
    tick();
    rd(1, 12'h340);
    #1 chk("mscratch_q2", rd_data[1], 64'h22); chk("count_2", W'(wq_count), W'(2));
    tick();
    rd(1, 12'h340);
    #1 chk("mscratch_q1", rd_data[1], 64'h22); chk("count_1", W'(wq_count), W'(1));
    tick();
    rd(1, 12'h340);
    #1 chk("mscratch_q0", rd_data[1], 64'h22); chk("count_0", W'(wq_count), W'(0));
    tick();

    // back-pressure: dropped writes never appear
    wr(0, 12'h340, 64'hA1); wr(1, 12'h340, 64'hA2); tick();
    wr(0, 12'h340, 64'hB1); wr(1, 12'h340, 64'hB2); tick();
    #1 chk("full_count", W'(wq_count), W'(3)); chk("full_not_ready", W'(wr_ready), W'(0));
    wr(0, 12'h340, 64'hC1); wr(1, 12'h340, 64'hC2); tick();
    #1 chk("ready_back", W'(wr_ready), W'(1)); chk("dropped_count", W'(wq_count), W'(2));
    tick(); tick();
    rd(0, 12'h340);
    #1 chk("dropped_not_landed", rd_data[0], 64'hB2); chk("drained", W'(wq_count), W'(0));
    tick();

    // trap flushes queued writes
    wr(0, 12'h341, 64'h2222); wr(1, 12'h343, 64'h3333); tick();
    wr(0, 12'h341, 64'h4444); wr(1, 12'h343, 64'h5555); tick();
    #1 chk("pre_trap_count", W'(wq_count), W'(3));
    trap_valid = 1'b1; trap_epc = 64'h1001; trap_cause = 64'h2; trap_tval = 64'h77;
    wr(0, 12'h340, 64'hEE);
    tick();
    rd(0, 12'h342); rd(1, 12'h343);
    #1 chk("trap_count", W'(wq_count), W'(0)); chk("trap_mepc", mepc, 64'h1000);
    chk("trap_mcause", rd_data[0], 64'h2); chk("trap_mtval", rd_data[1], 64'h77);
    tick(); tick();
    rd(0, 12'h340); rd(1, 12'h343);
    #1 chk("trap_flush_mepc", mepc, 64'h1000); chk("trap_flush_mtval", rd_data[1], 64'h77);
    chk("trap_drop_wr", rd_data[0], 64'hB2);
    tick();

    // legalization / decode table
    for (int i = 0; i < 10; i++) begin
      wr(0, tbl[i].a, tbl[i].wd); tick(); tick();
      rd(0, tbl[i].a);
      #1;
      chk($sformatf("tbl%0d_data", i), rd_data[0], tbl[i].exp_d);
      chk($sformatf("tbl%0d_ill", i), W'(rd_ill[0]), W'(tbl[i].exp_ill));
      tick();
    end

    // asynchronous reset in the middle of a drain
    wr(0, 12'h300, 64'h5); wr(1, 12'h305, 64'h4); tick();
    rd(0, 12'hB00);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", W'(wq_count), W'(0)); chk("arst_empty", W'(wq_empty), W'(1));
    chk("arst_ready", W'(wr_ready), W'(1)); chk("arst_mepc", mepc, '0);
    chk("arst_mtvec", mtvec, '0); chk("arst_mcycle", rd_data[0], '0);
    m_reset();
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b1;

    // random traffic against the model
    for (int c = 0; c < 600; c++) begin
      for (int ch = 0; ch < RD; ch++)
        if ($urandom_range(3) != 0) rd(ch, pool[$urandom_range(7)]);
      for (int ch = 0; ch < WR; ch++)
        if ($urandom_range(1) != 0) wr(ch, pool[$urandom_range(7)], {$urandom, $urandom});
      if ($urandom_range(15) == 0) begin
        trap_valid = 1'b1;
        trap_epc   = {$urandom, $urandom};
        trap_cause = W'($urandom_range(15));
        trap_tval  = {$urandom, $urandom};
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
